// File: rtl/cvxif_ooo_coprocessor.sv
// cvxif_ooo_coprocessor
// Out-of-order CV-X-IF coprocessor. Up to DEPTH instructions are in flight,
// each held in its own slot. A slot runs its latency down-counter
// (latency = low LAT_W bits of the result) and waits for its commit. Results
// are returned by slot index, lowest READY slot first. A presented result
// stays locked until the core accepts it.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   issue_*              issue request, operands, destination, accept
//   commit_*             commit / kill by instruction ID
//   result_*             result handshake and payload (result_we_o = valid)
//   flush_i              only with CVXIF_COPRO_FLUSH_EN: drop uncommitted slots
//
// Build option: define CVXIF_COPRO_FLUSH_EN to add the flush_i input.
//
// Slot states:
//   state  | meaning
//   FREE   | slot unused, may be allocated
//   EXEC   | latency counter still running
//   WAIT   | counter done, commit not yet seen
//   READY  | done and committed, eligible for result
module cvxif_ooo_coprocessor #(
   parameter int XLEN   = 64,
   parameter int ID_W   = 3,
   parameter int DEPTH  = 4,
   parameter int NUM_RS = 3,
   parameter int LAT_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
`ifdef CVXIF_COPRO_FLUSH_EN
   input  logic              flush_i,
`endif
   input  logic              issue_valid_i,
   output logic              issue_ready_o,
   input  logic [ID_W-1:0]   issue_id_i,
   input  logic [1:0]        issue_op_i,
   input  logic [XLEN-1:0]   issue_rs1_i,
   input  logic [XLEN-1:0]   issue_rs2_i,
   input  logic [XLEN-1:0]   issue_rs3_i,
   input  logic [4:0]        issue_rd_i,
   output logic              issue_accept_o,
   input  logic              commit_valid_i,
   input  logic [ID_W-1:0]   commit_id_i,
   input  logic              commit_kill_i,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic [ID_W-1:0]   result_id_o,
   output logic [4:0]        result_rd_o,
   output logic [XLEN-1:0]   result_data_o,
   output logic              result_we_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_FREE  = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_READY = 2'd3;

   localparam logic [1:0] OP_ADD2 = 2'b00;
   localparam logic [1:0] OP_ADD3 = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;

   logic [1:0]       state_q [DEPTH];
   logic [1:0]       state_d [DEPTH];
   logic [ID_W-1:0]  id_q    [DEPTH];
   logic [ID_W-1:0]  id_d    [DEPTH];
   logic [4:0]       rd_q    [DEPTH];
   logic [4:0]       rd_d    [DEPTH];
   logic [XLEN-1:0]  res_q   [DEPTH];
   logic [XLEN-1:0]  res_d   [DEPTH];
   logic [LAT_W-1:0] cnt_q   [DEPTH];
   logic [LAT_W-1:0] cnt_d   [DEPTH];
   logic             cmt_q   [DEPTH];
   logic             cmt_d   [DEPTH];
   logic             pres_lock_q, pres_lock_d;
   logic [IDX_W-1:0] pres_idx_q, pres_idx_d;

   logic             flush;
   logic             free_any, ready_any, op_legal, handshake, new_hit;
   logic [IDX_W-1:0] free_idx, ready_idx, sel_idx;
   logic [XLEN-1:0]  issue_res;

`ifdef CVXIF_COPRO_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   // A live slot's state follows from its counter and commit flag.
   function automatic logic [1:0] live_state(input logic [LAT_W-1:0] c, input logic cm);
      if (c != '0) return S_EXEC;
      return cm ? S_READY : S_WAIT;
   endfunction

   always_comb begin
      op_legal  = 1'b0;
      issue_res = '0;
      case (issue_op_i)
         OP_ADD2: begin op_legal = 1'b1;           issue_res = issue_rs1_i + issue_rs2_i; end
         OP_ADD3: begin op_legal = (NUM_RS == 3);  issue_res = issue_rs1_i + issue_rs2_i + issue_rs3_i; end
         OP_SUB:  begin op_legal = 1'b1;           issue_res = issue_rs1_i - issue_rs2_i; end
         default: ;
      endcase
   end

   // Lowest-index FREE and READY slots, from registered state only.
   always_comb begin
      free_any  = 1'b0;
      free_idx  = '0;
      ready_any = 1'b0;
      ready_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (state_q[i] == S_FREE) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (state_q[i] == S_READY) begin
            ready_any = 1'b1;
            ready_idx = IDX_W'(i);
         end
      end
   end

   assign issue_ready_o  = ~rst_i & free_any;
   assign issue_accept_o = issue_valid_i & issue_ready_o & op_legal & ~flush;

   // Once shown, the presented slot is held so a lower READY slot cannot preempt it.
   assign sel_idx        = pres_lock_q ? pres_idx_q : ready_idx;
   assign result_valid_o = ~rst_i & (pres_lock_q | ready_any);
   assign result_we_o    = result_valid_o;
   assign result_id_o    = id_q[sel_idx];
   assign result_rd_o    = rd_q[sel_idx];
   assign result_data_o  = res_q[sel_idx];
   assign handshake      = result_valid_o & result_ready_i;

   assign pres_lock_d = result_valid_o & ~result_ready_i;
   assign pres_idx_d  = sel_idx;
   assign new_hit     = commit_valid_i & (commit_id_i == issue_id_i);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         state_d[i] = state_q[i];
         id_d[i]    = id_q[i];
         rd_d[i]    = rd_q[i];
         res_d[i]   = res_q[i];
         cnt_d[i]   = cnt_q[i];
         cmt_d[i]   = cmt_q[i];
         if (state_q[i] != S_FREE) begin
            if (commit_valid_i && (id_q[i] == commit_id_i) && !commit_kill_i)
               cmt_d[i] = 1'b1;
            if (cnt_q[i] != '0)
               cnt_d[i] = cnt_q[i] - 1'b1;
            state_d[i] = live_state(cnt_d[i], cmt_d[i]);
            if (commit_valid_i && (id_q[i] == commit_id_i) && commit_kill_i)
               state_d[i] = S_FREE;
            if (flush && !cmt_d[i])
               state_d[i] = S_FREE;
            if (handshake && (sel_idx == IDX_W'(i)))
               state_d[i] = S_FREE;
         end else if (issue_accept_o && (free_idx == IDX_W'(i))) begin
            id_d[i]    = issue_id_i;
            rd_d[i]    = issue_rd_i;
            res_d[i]   = issue_res;
            cnt_d[i]   = issue_res[LAT_W-1:0];
            cmt_d[i]   = new_hit & ~commit_kill_i;
            state_d[i] = (new_hit && commit_kill_i) ? S_FREE
                                                    : live_state(cnt_d[i], cmt_d[i]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= S_FREE;
            id_q[i]    <= '0;
            rd_q[i]    <= '0;
            res_q[i]   <= '0;
            cnt_q[i]   <= '0;
            cmt_q[i]   <= 1'b0;
         end
         pres_lock_q <= 1'b0;
         pres_idx_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= state_d[i];
            id_q[i]    <= id_d[i];
            rd_q[i]    <= rd_d[i];
            res_q[i]   <= res_d[i];
            cnt_q[i]   <= cnt_d[i];
            cmt_q[i]   <= cmt_d[i];
         end
         pres_lock_q <= pres_lock_d;
         pres_idx_q  <= pres_idx_d;
      end
   end

endmodule

// File: tb/tb_cvxif_ooo_coprocessor.sv
// Bench for cvxif_ooo_coprocessor (default parameters, flush option off).
// Stimulus pushes expected results into a scoreboard queue; a monitor on the
// falling edge matches every accepted result by ID and checks that a stalled
// result stays stable.
module tb_cvxif_ooo_coprocessor;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        issue_valid_i = 1'b0;
   logic        issue_ready_o;
   logic [2:0]  issue_id_i = '0;
   logic [1:0]  issue_op_i = '0;
   logic [63:0] issue_rs1_i = '0;
   logic [63:0] issue_rs2_i = '0;
   logic [63:0] issue_rs3_i = '0;
   logic [4:0]  issue_rd_i = '0;
   logic        issue_accept_o;
   logic        commit_valid_i = 1'b0;
   logic [2:0]  commit_id_i = '0;
   logic        commit_kill_i = 1'b0;
   logic        result_valid_o;
   logic        result_ready_i = 1'b1;
   logic [2:0]  result_id_o;
   logic [4:0]  result_rd_o;
   logic [63:0] result_data_o;
   logic        result_we_o;

   cvxif_ooo_coprocessor dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .issue_valid_i  (issue_valid_i),
      .issue_ready_o  (issue_ready_o),
      .issue_id_i     (issue_id_i),
      .issue_op_i     (issue_op_i),
      .issue_rs1_i    (issue_rs1_i),
      .issue_rs2_i    (issue_rs2_i),
      .issue_rs3_i    (issue_rs3_i),
      .issue_rd_i     (issue_rd_i),
      .issue_accept_o (issue_accept_o),
      .commit_valid_i (commit_valid_i),
      .commit_id_i    (commit_id_i),
      .commit_kill_i  (commit_kill_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_id_o    (result_id_o),
      .result_rd_o    (result_rd_o),
      .result_data_o  (result_data_o),
      .result_we_o    (result_we_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [1:0] ADD2 = 2'b00;
   localparam logic [1:0] ADD3 = 2'b01;
   localparam logic [1:0] SUB  = 2'b10;
   localparam logic [1:0] ILL  = 2'b11;

   typedef struct packed {
      logic [2:0]  id;
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_exp(input logic [2:0] id, input logic [4:0] rd, input logic [63:0] data);
      exp_t e;
      e.id = id; e.rd = rd; e.data = data;
      exp_q.push_back(e);
   endtask

   // One issue cycle; optional commit of the same ID in that cycle.
   task automatic do_issue(input logic [2:0] id, input logic [1:0] op,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           input logic [4:0] rd, input logic cmt, input logic exp_acc);
      issue_valid_i  = 1'b1;
      issue_id_i     = id;
      issue_op_i     = op;
      issue_rs1_i    = a;
      issue_rs2_i    = b;
      issue_rs3_i    = c;
      issue_rd_i     = rd;
      commit_valid_i = cmt;
      commit_id_i    = id;
      commit_kill_i  = 1'b0;
      #1 chk("issue_accept", issue_accept_o, exp_acc);
      tick();
      issue_valid_i  = 1'b0;
      commit_valid_i = 1'b0;
   endtask

   task automatic do_commit(input logic [2:0] id, input logic kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int c = 0;
      while (exp_q.size() != 0 && c < max_cyc) begin
         tick();
         c++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard monitor.
   initial begin : monitor
      logic        held_v;
      logic [2:0]  h_id;
      logic [4:0]  h_rd;
      logic [63:0] h_data;
      int          idx;
      held_v = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            held_v = 1'b0;
         end else if (result_valid_o) begin
            chk("we_eq_valid", result_we_o, 1'b1);
            if (held_v) begin
               chk("stall_id",   result_id_o,   h_id);
               chk("stall_rd",   result_rd_o,   h_rd);
               chk("stall_data", result_data_o, h_data);
            end
            if (result_ready_i) begin
               held_v = 1'b0;
               idx = -1;
               for (int k = 0; k < exp_q.size(); k++)
                  if (idx < 0 && exp_q[k].id == result_id_o) idx = k;
               n_tests++;
               if (idx < 0) begin
                  n_fail++;
                  $display("FAIL unexpected_result: got id %0d data 0x%0h, required no result",
                           result_id_o, result_data_o);
               end else begin
                  chk("result_rd",   result_rd_o,   exp_q[idx].rd);
                  chk("result_data", result_data_o, exp_q[idx].data);
                  exp_q.delete(idx);
               end
            end else begin
               held_v = 1'b1;
               h_id   = result_id_o;
               h_rd   = result_rd_o;
               h_data = result_data_o;
            end
         end else if (held_v) begin
            chk("valid_held", result_valid_o, 1'b1);
            held_v = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      // Reset
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_issue_ready", issue_ready_o, 1'b0);
      chk("rst_result_valid", result_valid_o, 1'b0);
      rst_i = 1'b0;
      #1;
      chk("post_rst_issue_ready", issue_ready_o, 1'b1);
      chk("post_rst_result_valid", result_valid_o, 1'b0);

      // ADD2 3+4 with commit in the issue cycle: latency 7
      push_exp(3'd1, 5'd5, 64'd7);
      do_issue(3'd1, ADD2, 64'd3, 64'd4, 64'd0, 5'd5, 1'b1, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         chk("t1_not_yet_valid", result_valid_o, 1'b0);
         tick();
      end
      chk("t1_valid", result_valid_o, 1'b1);
      chk("t1_id", result_id_o, 3'd1);
      chk("t1_data", result_data_o, 64'd7);
      tick();
      drain(4);

      // Fill all slots with uncommitted latency-0 ops
      for (int k = 0; k < 4; k++)
         do_issue(3'(k), ADD2, 64'd0, 64'd0, 64'd0, 5'(10 + k), 1'b0, 1'b1);
      chk("full_issue_ready", issue_ready_o, 1'b0);
      do_issue(3'd4, ADD2, 64'd1, 64'd1, 64'd0, 5'd9, 1'b0, 1'b0);
      push_exp(3'd2, 5'd12, 64'd0);
      do_commit(3'd2, 1'b0);
      chk("full_still_busy", issue_ready_o, 1'b0);
      chk("commit2_valid", result_valid_o, 1'b1);
      chk("commit2_id", result_id_o, 3'd2);
      tick();
      chk("after_hs_issue_ready", issue_ready_o, 1'b1);
      do_commit(3'd0, 1'b1);
      do_commit(3'd1, 1'b1);
      do_commit(3'd3, 1'b1);
      tick();
      chk("after_kills_valid", result_valid_o, 1'b0);
      drain(4);

      // Out-of-order return: latency 15 then latency 0
      push_exp(3'd0, 5'd6, 64'h0F);
      push_exp(3'd1, 5'd7, 64'h10);
      do_issue(3'd0, ADD2, 64'h0F, 64'd0, 64'd0, 5'd6, 1'b1, 1'b1);
      do_issue(3'd1, ADD2, 64'h10, 64'd0, 64'd0, 5'd7, 1'b1, 1'b1);
      chk("ooo_valid", result_valid_o, 1'b1);
      chk("ooo_first_id", result_id_o, 3'd1);
      drain(40);

      // Kill and slot reuse
      for (int k = 3; k < 7; k++)
         do_issue(3'(k), ADD2, 64'd5, 64'd0, 64'd0, 5'(k), 1'b0, 1'b1);
      chk("kill_full", issue_ready_o, 1'b0);
      commit_valid_i = 1'b1; commit_id_i = 3'd3; commit_kill_i = 1'b1;
      issue_valid_i = 1'b1; issue_id_i = 3'd7; issue_op_i = ADD2;
      issue_rs1_i = 64'd2; issue_rs2_i = 64'd0; issue_rd_i = 5'd12;
      #1;
      chk("kill_cycle_accept", issue_accept_o, 1'b0);
      chk("kill_cycle_ready", issue_ready_o, 1'b0);
      tick();
      commit_id_i = 3'd7; commit_kill_i = 1'b0;
      #1;
      chk("reuse_ready", issue_ready_o, 1'b1);
      chk("reuse_accept", issue_accept_o, 1'b1);
      push_exp(3'd7, 5'd12, 64'd2);
      tick();
      issue_valid_i = 1'b0; commit_valid_i = 1'b0;
      do_commit(3'd3, 1'b0);
      do_commit(3'd4, 1'b1);
      do_commit(3'd5, 1'b1);
      do_commit(3'd6, 1'b1);
      drain(20);
      repeat (10) tick();
      chk("kill_no_result", result_valid_o, 1'b0);
      chk("kill_all_free", issue_ready_o, 1'b1);

      // Backpressure, no preemption by a lower READY slot
      result_ready_i = 1'b0;
      push_exp(3'd1, 5'd8, 64'h22);
      push_exp(3'd2, 5'd9, 64'h30);
      do_issue(3'd1, ADD2, 64'h22, 64'd0, 64'd0, 5'd8, 1'b1, 1'b1);
      do_issue(3'd2, ADD2, 64'h30, 64'd0, 64'd0, 5'd9, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", result_valid_o, 1'b1);
         chk("bp_id", result_id_o, 3'd2);
         chk("bp_data", result_data_o, 64'h30);
         tick();
      end
      result_ready_i = 1'b1;
      #1 chk("bp_release_id", result_id_o, 3'd2);
      tick();
      chk("bp_next_valid", result_valid_o, 1'b1);
      chk("bp_next_id", result_id_o, 3'd1);
      chk("bp_next_data", result_data_o, 64'h22);
      drain(5);

      // ADD3 and SUB wraparound
      push_exp(3'd1, 5'd13, 64'd6);
      do_issue(3'd1, ADD3, 64'd1, 64'd2, 64'd3, 5'd13, 1'b1, 1'b1);
      push_exp(3'd4, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF);
      do_issue(3'd4, SUB, 64'd0, 64'd1, 64'd0, 5'd14, 1'b1, 1'b1);
      drain(40);

      // Illegal op takes no slot
      for (int k = 0; k < 3; k++)
         do_issue(3'(k), ADD2, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
      do_issue(3'd3, ILL, 64'd5, 64'd5, 64'd5, 5'd1, 1'b1, 1'b0);
      chk("illegal_slot_free", issue_ready_o, 1'b1);
      do_issue(3'd5, ADD2, 64'd3, 64'd0, 64'd0, 5'd15, 1'b1, 1'b1);
      chk("last_slot_full", issue_ready_o, 1'b0);

      // Reset mid-run discards everything, including committed id 5
      rst_i = 1'b1;
      #1;
      chk("midrst_valid", result_valid_o, 1'b0);
      chk("midrst_ready", issue_ready_o, 1'b0);
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      chk("midrst_release_ready", issue_ready_o, 1'b1);
      repeat (10) tick();
      chk("midrst_no_result", result_valid_o, 1'b0);
      for (int k = 0; k < 4; k++)
         do_issue(3'(k), ADD2, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
      chk("midrst_refill_full", issue_ready_o, 1'b0);

      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      repeat (3) tick();
      chk("final_pending", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
